// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared opcodes and checker state encoding
package alu_chk_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational golden model of the 3-bit-opcode ALU
module alu_ref_model
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHL:  y = a << 1;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - on-chip ALU response checker with latency-matched reference
module alu_resp_checker
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LAT   = 1,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    num_vec,
    input  logic             in_valid,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pass_cnt,
    output logic [CW-1:0]    fail_cnt,
    output logic             err_flag,
    output logic [2:0]       err_sel,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_got
);

    localparam int PW = 3 + 3 * WIDTH;

    chk_state_t       state, next_state;
    logic [CW-1:0]    num_q, acc_cnt;
    logic [WIDTH-1:0] exp_y;
    logic             start_ok, accept, last_accept, pipe_busy;
    logic             cmp_vld, mismatch;
    logic [PW-1:0]    cmp_dat;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .sel (sel),
        .a   (a),
        .b   (b),
        .y   (exp_y)
    );

    assign start_ok    = start && (state == S_IDLE || state == S_DONE);
    assign accept      = in_valid && (state == S_RUN);
    assign last_accept = accept && ((acc_cnt + CW'(1)) == num_q);

    // Stimulus and expected result travel together so a mismatch can be reported in full.
    generate
        if (LAT == 0) begin : g_comb
            assign cmp_vld   = accept;
            assign cmp_dat   = {sel, a, b, exp_y};
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0] vld_q;
            logic [PW-1:0]  dat_q [LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int k = 0; k < LAT; k++) dat_q[k] <= '0;
                end else begin
                    vld_q[0] <= accept;
                    dat_q[0] <= {sel, a, b, exp_y};
                    for (int k = 1; k < LAT; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign cmp_vld   = vld_q[LAT-1];
            assign cmp_dat   = dat_q[LAT-1];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    assign mismatch = (dut_y != cmp_dat[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = (num_vec == '0) ? S_DRAIN : S_RUN;
            S_RUN:          if (last_accept) next_state = S_DRAIN;
            S_DRAIN:        if (!pipe_busy) next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == S_RUN) || (next_state == S_DRAIN);
            done <= (next_state == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            num_q    <= rst_n ? num_vec : '0;
            acc_cnt  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_flag <= 1'b0;
            err_sel  <= '0;
            err_a    <= '0;
            err_b    <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else begin
            if (accept) acc_cnt <= acc_cnt + CW'(1);
            if (cmp_vld && !mismatch && pass_cnt != '1) pass_cnt <= pass_cnt + CW'(1);
            if (cmp_vld && mismatch) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
                // Only the first mismatch of a run is kept for diagnosis.
                if (!err_flag) begin
                    err_flag <= 1'b1;
                    err_sel  <= cmp_dat[PW-1 -: 3];
                    err_a    <= cmp_dat[3*WIDTH-1 -: WIDTH];
                    err_b    <= cmp_dat[2*WIDTH-1 -: WIDTH];
                    err_exp  <= cmp_dat[WIDTH-1:0];
                    err_got  <= dut_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_resp_checker.sv
// tb/tb_alu_resp_checker.sv - scoreboard bench driving LAT=0 and LAT=1 checkers in parallel
module tb_alu_resp_checker;

    localparam int W  = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic         v;
        logic         st;
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } stim_t;

    typedef struct packed {
        logic [CW-1:0] pass;
        logic [CW-1:0] fail;
        logic          ef;
        logic [2:0]    sel;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  ex;
        logic [W-1:0]  got;
        logic [31:0]   de;
    } res_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic [2:0]    sel = '0;
    logic [W-1:0]  a = '0, b = '0, cur_y = '0, dut_y1 = '0;

    logic busy0, done0, ef0, busy1, done1, ef1;
    logic [CW-1:0] pass0, fail0, pass1, fail1;
    logic [2:0]    es0, es1;
    logic [W-1:0]  ea0, eb0, ex0, eg0, ea1, eb1, ex1, eg1;

    int    edge_no = 0;
    int    n_vec = 0, n_chk = 0, n_err = 0;
    stim_t stim_q[$];
    res_t  q0[$], q1[$];

    alu_resp_checker #(.WIDTH(W), .LAT(0), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .in_valid(in_valid),
        .sel(sel), .a(a), .b(b), .dut_y(cur_y), .busy(busy0), .done(done0),
        .pass_cnt(pass0), .fail_cnt(fail0), .err_flag(ef0), .err_sel(es0),
        .err_a(ea0), .err_b(eb0), .err_exp(ex0), .err_got(eg0));

    alu_resp_checker #(.WIDTH(W), .LAT(1), .CW(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .in_valid(in_valid),
        .sel(sel), .a(a), .b(b), .dut_y(dut_y1), .busy(busy1), .done(done1),
        .pass_cnt(pass1), .fail_cnt(fail1), .err_flag(ef1), .err_sel(es1),
        .err_a(ea1), .err_b(eb1), .err_exp(ex1), .err_got(eg1));

    always #5 clk = ~clk;

    // Edge counter plus a one-cycle-latency ALU stand-in for the LAT=1 checker.
    always @(posedge clk) begin
        edge_no++;
        dut_y1 <= cur_y;
    end

    function automatic logic [W-1:0] ref_y(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        int m;
        int xi;
        int yi;
        m  = 1 << W;
        xi = int'(x);
        yi = int'(y);
        case (s)
            3'd0:    r = xi + yi;
            3'd1:    r = xi - yi + m;
            3'd2:    r = xi & yi;
            3'd3:    r = xi | yi;
            3'd4:    r = xi ^ yi;
            3'd5:    r = m - 1 - xi;
            3'd6:    r = 2 * xi;
            default: r = yi;
        endcase
        return W'(r % m);
    endfunction

    task automatic chk(input string nm, input int id, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[lat%0d]: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    task automatic check_res(input int id, input res_t act, input logic bz);
        res_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_done[lat%0d]: got done=1 expected no pending run", id);
            return;
        end
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("pass_cnt", id, act.pass, e.pass);
        chk("fail_cnt", id, act.fail, e.fail);
        chk("err_flag", id, act.ef, e.ef);
        chk("err_sel", id, act.sel, e.sel);
        chk("err_a", id, act.a, e.a);
        chk("err_b", id, act.b, e.b);
        chk("err_exp", id, act.ex, e.ex);
        chk("err_got", id, act.got, e.got);
        chk("done_edge", id, act.de, e.de);
        chk("busy_at_done", id, bz, 0);
    endtask

    logic pd0 = 1'b0, pd1 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (done0 && !pd0)
            check_res(0, '{pass:pass0, fail:fail0, ef:ef0, sel:es0, a:ea0, b:eb0, ex:ex0, got:eg0, de:edge_no}, busy0);
        if (done1 && !pd1)
            check_res(1, '{pass:pass1, fail:fail1, ef:ef1, sel:es1, a:ea1, b:eb1, ex:ex1, got:eg1, de:edge_no}, busy1);
        pd0 = done0;
        pd1 = done1;
    end

    task automatic push_vec(input logic v, input logic st, input logic [2:0] s,
                            input logic [W-1:0] x, input logic [W-1:0] y, input int badval);
        stim_t t;
        t.v   = v;
        t.st  = st;
        t.sel = s;
        t.a   = x;
        t.b   = y;
        t.y   = (badval < 0) ? ref_y(s, x, y) : badval[W-1:0];
        stim_q.push_back(t);
    endtask

    task automatic push_exp(input res_t e, input int last_edge, input int nv);
        res_t e0, e1;
        e0 = e;
        e1 = e;
        e0.de = last_edge + 1;
        e1.de = last_edge + 1 + ((nv > 0) ? 1 : 0);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Only the first nv valid vectors after start count; anything later lands in DRAIN/DONE.
    task automatic run_stim(input int nv);
        res_t e;
        int acc;
        int last_edge;
        int budget;
        logic [W-1:0] good;
        e   = '0;
        acc = 0;
        @(negedge clk);
        start     = 1'b1;
        num_vec   = CW'(nv);
        last_edge = edge_no + 1;
        if (nv == 0) push_exp(e, last_edge, nv);
        @(negedge clk);
        start = 1'b0;
        foreach (stim_q[i]) begin
            in_valid = stim_q[i].v;
            start    = stim_q[i].st;
            sel      = stim_q[i].sel;
            a        = stim_q[i].a;
            b        = stim_q[i].b;
            cur_y    = stim_q[i].y;
            if (stim_q[i].v) n_vec++;
            if (stim_q[i].v && acc < nv) begin
                acc++;
                last_edge = edge_no + 1;
                good = ref_y(stim_q[i].sel, stim_q[i].a, stim_q[i].b);
                if (good == stim_q[i].y) e.pass++;
                else begin
                    e.fail++;
                    if (!e.ef) begin
                        e.ef  = 1'b1;
                        e.sel = stim_q[i].sel;
                        e.a   = stim_q[i].a;
                        e.b   = stim_q[i].b;
                        e.ex  = good;
                        e.got = stim_q[i].y;
                    end
                end
                if (acc == nv) push_exp(e, last_edge, nv);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        budget   = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout: got %0d/%0d pending runs expected 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        stim_q.delete();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_busy"}, 0, busy0, 0);      chk({nm, "_busy"}, 1, busy1, 0);
        chk({nm, "_done"}, 0, done0, 0);      chk({nm, "_done"}, 1, done1, 0);
        chk({nm, "_pass"}, 0, pass0, 0);      chk({nm, "_pass"}, 1, pass1, 0);
        chk({nm, "_fail"}, 0, fail0, 0);      chk({nm, "_fail"}, 1, fail1, 0);
        chk({nm, "_err"}, 0, {ef0, es0, ea0, eb0, ex0, eg0}, 0);
        chk({nm, "_err"}, 1, {ef1, es1, ea1, eb1, ex1, eg1}, 0);
    endtask

    initial begin
        int nv;
        int got_v;
        logic [W-1:0] x, y;
        logic [2:0] s;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All opcodes, correct responses.
        for (int i = 0; i < 8; i++) push_vec(1, 0, 3'(i), 3'd5, 3'd3, -1);
        run_stim(8);
        // Single wrong answer on the add (6+3 wraps to 1, DUT says 0).
        for (int i = 0; i < 8; i++) push_vec(1, 0, 3'(i), 3'd6, 3'd3, (i == 0) ? 0 : -1);
        run_stim(8);
        // Two wrong answers; the first must stay latched.
        for (int i = 0; i < 8; i++)
            push_vec(1, 0, 3'(i), 3'd6, 3'd3, (i == 1 || i == 4) ? int'(ref_y(3'(i), 3'd6, 3'd3) ^ 3'd1) : -1);
        run_stim(8);
        // Empty run, then a run with a stray start in RUN.
        run_stim(0);
        for (int i = 0; i < 5; i++) push_vec(1, (i == 2), 3'(i + 2), 3'(i), 3'(7 - i), -1);
        run_stim(5);

        // Abort mid-run after three vectors.
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'd8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i);
            a        = 3'd2;
            b        = 3'd1;
            cur_y    = (i == 1) ? 3'd0 : ref_y(3'(i), 3'd2, 3'd1);
            n_vec++;
            @(negedge clk);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_cleared("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_vec(1, 0, 3'(i + 4), 3'(i), 3'(i + 1), -1);
        run_stim(4);

        // Gapped valid pattern with extra pulses trailing into DRAIN/DONE.
        for (int i = 0; i < 8; i++) begin
            x = 3'($urandom);
            y = 3'($urandom);
            s = 3'($urandom);
            push_vec((i != 1 && i != 4), 0, s, x, y, -1);
        end
        run_stim(4);

        for (int r = 0; r < 30; r++) begin
            nv    = $urandom_range(0, 12);
            got_v = 0;
            while (got_v < nv) begin
                x = 3'($urandom);
                y = 3'($urandom);
                s = 3'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    push_vec(1, ($urandom_range(0, 7) == 0), s, x, y,
                             ($urandom_range(0, 6) == 0) ? int'(ref_y(s, x, y) ^ 3'($urandom_range(1, 7))) : -1);
                    got_v++;
                end else begin
                    push_vec(0, 0, s, x, y, -1);
                end
            end
            for (int t = 0; t < int'($urandom_range(0, 3)); t++)
                push_vec(1'($urandom), 0, 3'($urandom), 3'($urandom), 3'($urandom), 0);
            run_stim(nv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_resp_checker.md
Name: alu_resp_checker

Overview:
- Synthesizable response checker for the 3-bit ALU. Sits on the DUT output side and receives the same sel/a/b stimulus that drives the ALU.
- Computes the expected result with a built-in reference model and delays it to match DUT latency. Compares it against the DUT result.
- Counts passes and fails, latches the first mismatch and signals completion after a programmed number of vectors.
- Replaces manual $monitor/$strobe inspection with on-chip self-checking.

Parameters:
- WIDTH, 3, operand/result width in bits.
- LAT, 1, DUT latency in clock cycles, range 0..8. LAT=0 means combinational: dut_y is compared in the same cycle as in_valid.
- CW, 16, width of the vector and pass/fail counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a check run.
- num_vec  in  CW  number of vectors in the run; sampled when start is accepted.
- in_valid  in  1  stimulus (sel/a/b) is valid this cycle.
- sel  in  3  ALU opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- dut_y  in  WIDTH  DUT result, valid LAT cycles after the matching in_valid.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass_cnt  out  CW  count of matching results.
- fail_cnt  out  CW  count of mismatching results.
- err_flag  out  1  at least one mismatch occurred this run.
- err_sel, err_a, err_b  out  3/WIDTH/WIDTH  stimulus of the first mismatch.
- err_exp, err_got  out  WIDTH/WIDTH  expected and received result of the first mismatch.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs, counters, err_* registers and pipeline valid bits clear to 0.
  - Reset mid-run aborts the run; no partial results are kept.
- Opcodes, all results truncated to WIDTH bits:
  - 000 a+b
  - 001 a-b (two's complement wrap)
  - 010 a&b
  - 011 a|b
  - 100 a^b
  - 101 ~a
  - 110 a<<1
  - 111 b
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_valid is ignored. On start: latch num_vec, clear counters, err_flag and err_* registers, reset the accepted count, go to RUN. If num_vec==0, go directly to DRAIN instead.
  - RUN: each in_valid accepts one vector. exp = ref(sel,a,b) and the stimulus enter a LAT-stage shift pipeline tagged valid. When the accepted count reaches num_vec (including the accepting cycle), go to DRAIN. start is ignored.
  - DRAIN: in_valid is ignored. Stay until no valid tag remains in the pipeline, then go to DONE. With LAT=0, DRAIN lasts exactly 1 cycle.
  - DONE: done=1. Counters and err_* hold. start behaves as in IDLE.
- Compare point: when a valid tag reaches the pipeline output (stage LAT; with LAT=0, the same cycle as in_valid), compare dut_y with exp.
  - Equal: pass_cnt++.
  - Not equal: fail_cnt++. If err_flag==0, capture err_* and set err_flag.
  - Later mismatches never overwrite err_* registers.
- Counters saturate at all-ones and do not wrap.
- Results emerging in the same cycle as the final acceptance are still counted.
- in_valid back-to-back every cycle is fully supported; no backpressure exists.
- busy and done are registered outputs. busy rises the cycle after start is accepted.
- Invariant: pass_cnt+fail_cnt == num_vec at DONE (no saturation case).

Decomposition:
- Package alu_chk_pkg holds:
  - opcode localparams OP_ADD..OP_PASSB (3'b000..3'b111);
  - FSM state encoding (2 bits: IDLE=0, RUN=1, DRAIN=2, DONE=3).
- Sub-module alu_ref_model: purely combinational (sel, a, b) -> exp. It is shared with future ALU blocks.
- The delay pipeline and the FSM stay in the top module.

Test Plan:
1. LAT=1, start with num_vec=8. Drive all 8 opcodes with a=3'b101, b=3'b011 and a correct DUT model -> done after 8+1+1 cycles, pass_cnt=8, fail_cnt=0, err_flag=0.
2. Same run, but DUT returns 3'b000 for sel=3'b000 (expected 5+3=3'b000 after wrap; use a=6, b=3 -> exp 3'b001) -> fail_cnt=1, err_sel=000, err_a=110, err_b=011, err_exp=001, err_got=000.
3. Two mismatches at vectors 2 and 5 -> fail_cnt=2; err_* still hold vector 2 values.
4. LAT=0, num_vec=0 -> busy for 1 cycle, then done with both counts 0. Also: start during RUN is ignored and the count is unaffected.
5. Pull rst_n low for one cycle mid-RUN after 3 vectors -> next cycle: IDLE, all counters 0, busy=0, done=0. Follow with a fresh run of 4 vectors -> pass_cnt=4.
6. Drive in_valid with a gap pattern 1,0,1,1,0,1 and num_vec=4 -> exactly 4 compares. Extra in_valid pulses in DRAIN/DONE are not counted.
